// File: rtl/pll_reset_sequencer_if.sv
// Lock/soft-reset inputs and reset/status outputs of pll_reset_sequencer.
// master drives the PLL lock and soft reset; slave is the sequencer itself.
interface pll_reset_sequencer_if;
  logic       pll_lock;
  logic       soft_reset;
  logic       core_reset;
  logic       core_resetn;
  logic       ready;
  logic [7:0] lock_loss_count;

  modport master (
    output pll_lock,
    output soft_reset,
    input  core_reset,
    input  core_resetn,
    input  ready,
    input  lock_loss_count
  );

  modport slave (
    input  pll_lock,
    input  soft_reset,
    output core_reset,
    output core_resetn,
    output ready,
    output lock_loss_count
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Core reset sequencer for the PLL clock domain: qualifies PLL lock, then holds and releases reset.
// Optional lock-loss counter is built only when PLL_RST_LOSS_CNT_EN is defined.
module pll_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 256,
  parameter int HOLD_CYCLES        = 16,
  parameter int SYNC_STAGES        = 2
) (
  input logic                  clk,
  input logic                  resetn,
  pll_reset_sequencer_if.slave bus
);

  localparam int MAX_CYC = (LOCK_STABLE_CYCLES > HOLD_CYCLES) ? LOCK_STABLE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                 state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   lock_s;
  logic                   core_reset_r;
  logic                   core_resetn_r;
  logic                   ready_r;

  // Lock synchronizer; the only reader of the raw PLL lock flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], bus.pll_lock};
    end
  end

  assign lock_s = sync_r[SYNC_STAGES-1];

  // Sequencing FSM; reset outputs follow the next state so they never glitch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r       <= WAIT_LOCK;
      cnt_r         <= '0;
      core_reset_r  <= 1'b1;
      core_resetn_r <= 1'b0;
      ready_r       <= 1'b0;
    end else begin
      core_reset_r  <= 1'b1;
      core_resetn_r <= 1'b0;
      ready_r       <= 1'b0;
      case (state_r)
        WAIT_LOCK: begin
          cnt_r <= '0;
          if (lock_s) begin
            state_r <= STABLE;
          end else begin
            state_r <= WAIT_LOCK;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_r <= WAIT_LOCK;
            cnt_r   <= '0;
          end else if (cnt_r == STABLE_LAST) begin
            state_r <= HOLD;
            cnt_r   <= '0;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
          end
        end
        HOLD: begin
          if (!lock_s) begin
            state_r <= WAIT_LOCK;
            cnt_r   <= '0;
          end else if (bus.soft_reset) begin
            state_r <= HOLD;
            cnt_r   <= '0;
          end else if (cnt_r == HOLD_LAST) begin
            state_r       <= RUN;
            cnt_r         <= '0;
            core_reset_r  <= 1'b0;
            core_resetn_r <= 1'b1;
            ready_r       <= 1'b1;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
          end
        end
        RUN: begin
          cnt_r <= '0;
          if (!lock_s) begin
            state_r <= WAIT_LOCK;
          end else if (bus.soft_reset) begin
            state_r <= HOLD;
          end else begin
            state_r       <= RUN;
            core_reset_r  <= 1'b0;
            core_resetn_r <= 1'b1;
            ready_r       <= 1'b1;
          end
        end
        default: begin
          state_r <= WAIT_LOCK;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign bus.core_reset  = core_reset_r;
  assign bus.core_resetn = core_resetn_r;
  assign bus.ready       = ready_r;

`ifdef PLL_RST_LOSS_CNT_EN
  logic [7:0] loss_cnt_r;

  // Saturating count of lock losses seen while running; only resetn clears it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      loss_cnt_r <= 8'h00;
    end else if ((state_r == RUN) && !lock_s && (loss_cnt_r != 8'hFF)) begin
      loss_cnt_r <= loss_cnt_r + 8'h01;
    end else begin
      loss_cnt_r <= loss_cnt_r;
    end
  end

  assign bus.lock_loss_count = loss_cnt_r;
`else
  assign bus.lock_loss_count = 8'h00;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: vector table, corner sequences, random run vs a lock-streak model.
module tb_pll_reset_sequencer;

  localparam int LSC = 4;
  localparam int HC  = 2;
  localparam int SS  = 2;
`ifdef PLL_RST_LOSS_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk    = 1'b0;
  bit   clk_en = 1'b1;
  logic resetn = 1'b0;

  pll_reset_sequencer_if bus ();

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES(LSC),
    .HOLD_CYCLES       (HC),
    .SYNC_STAGES       (SS)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  // Gateable clock so the asynchronous reset can be exercised with clk stopped.
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: synchronizer delay plus consecutive-lock streak arithmetic.
  bit q[$];
  int streak;
  int since_sr;
  bit m_run;
  int m_loss;

  typedef struct {
    bit lock;
    bit sr;
    bit cr;
    bit rdy;
    int cnt;
  } vec_t;
  vec_t tbl[28];

  function automatic int exp_cnt(input int m);
    return CNT_ON ? m : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < SS; i++) q.push_back(1'b0);
    streak   = 0;
    since_sr = 1000;
    m_run    = 1'b0;
    m_loss   = 0;
  endtask

  task automatic model_step(input bit lock, input bit sr);
    bit ls;
    bit prev_run;
    ls = q.pop_front();
    q.push_back(lock);
    prev_run = m_run;
    if (ls) begin
      if (streak < 100000) streak++;
    end else begin
      streak = 0;
    end
    // A soft reset counts only once hold has been reached with lock present.
    if (ls && sr && (streak >= 2 + LSC)) since_sr = 0;
    else if (since_sr < 1000) since_sr++;
    m_run = (streak >= 1 + LSC + HC) && (since_sr >= HC);
    if (!ls && prev_run && (m_loss < 255)) m_loss++;
  endtask

  task automatic cyc(input bit lock, input bit sr);
    bus.pll_lock   = lock;
    bus.soft_reset = sr;
    @(posedge clk);
    model_step(lock, sr);
    @(negedge clk);
    chk("mdl_core_reset", bus.core_reset, m_run ? 0 : 1);
    chk("mdl_core_resetn", bus.core_resetn, m_run ? 1 : 0);
    chk("mdl_ready", bus.ready, m_run ? 1 : 0);
    chk("mdl_loss_count", bus.lock_loss_count, exp_cnt(m_loss));
  endtask

  task automatic do_reset(input bit lock);
    resetn         = 1'b0;
    bus.pll_lock   = lock;
    bus.soft_reset = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    chk("rst_core_reset", bus.core_reset, 1);
    chk("rst_core_resetn", bus.core_resetn, 0);
    chk("rst_ready", bus.ready, 0);
    chk("rst_loss_count", bus.lock_loss_count, 0);
    resetn = 1'b1;
  endtask

  task automatic count_release(input string name, input int exp_edges);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc(1'b1, 1'b0);
      n++;
      if (bus.core_reset === 1'b0) seen = 1'b1;
    end
    chk(name, seen ? n : -1, exp_edges);
  endtask

  task automatic count_loss(input string name, input int exp_edges);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc(1'b0, 1'b0);
      n++;
      if (bus.core_reset === 1'b1) seen = 1'b1;
    end
    chk(name, seen ? n : -1, exp_edges);
  endtask

  task automatic async_check(input string name);
    clk_en = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk({name, "_core_reset"}, bus.core_reset, 1);
    chk({name, "_core_resetn"}, bus.core_resetn, 0);
    chk({name, "_ready"}, bus.ready, 0);
    chk({name, "_loss_count"}, bus.lock_loss_count, 0);
    model_reset();
    #1;
    clk_en         = 1'b1;
    bus.pll_lock   = 1'b1;
    bus.soft_reset = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic setv(input int i, input bit l, input bit s, input bit c, input bit r, input int n);
    tbl[i].lock = l;
    tbl[i].sr   = s;
    tbl[i].cr   = c;
    tbl[i].rdy  = r;
    tbl[i].cnt  = n;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Entry i is the stimulus sampled on edge i+1 after reset release and the outputs after it.
    for (int i = 0; i < 8; i++) setv(i, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    setv(8,  1'b1, 1'b0, 1'b0, 1'b1, 0);
    setv(9,  1'b1, 1'b1, 1'b1, 1'b0, 0);
    setv(10, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    setv(11, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    setv(12, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    setv(13, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    setv(14, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    for (int i = 15; i < 23; i++) setv(i, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    setv(23, 1'b1, 1'b0, 1'b0, 1'b1, 1);
    setv(24, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    setv(25, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    setv(26, 1'b0, 1'b1, 1'b1, 1'b0, 2);
    setv(27, 1'b0, 1'b0, 1'b1, 1'b0, 2);

    bus.pll_lock   = 1'b1;
    bus.soft_reset = 1'b0;
    do_reset(1'b1);
    for (int i = 0; i < 28; i++) begin
      bus.pll_lock   = tbl[i].lock;
      bus.soft_reset = tbl[i].sr;
      @(posedge clk);
      model_step(tbl[i].lock, tbl[i].sr);
      @(negedge clk);
      chk($sformatf("tbl%0d_core_reset", i), bus.core_reset, tbl[i].cr);
      chk($sformatf("tbl%0d_core_resetn", i), bus.core_resetn, !tbl[i].cr);
      chk($sformatf("tbl%0d_ready", i), bus.ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_loss_count", i), bus.lock_loss_count, exp_cnt(tbl[i].cnt));
    end

    // Lock glitch while qualifying: full restart, no loss counted.
    do_reset(1'b1);
    repeat (3) cyc(1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b0);
    count_release("glitch_release_edge", 9);
    chk("glitch_loss_count", bus.lock_loss_count, 0);

    // Lock loss while running, then relock.
    count_loss("run_loss_edge", 3);
    chk("run_loss_count", bus.lock_loss_count, exp_cnt(1));
    count_release("relock_release_edge", 9);

    // Repeated losses saturate the counter.
    repeat (300) begin
      repeat (9) cyc(1'b1, 1'b0);
      repeat (3) cyc(1'b0, 1'b0);
    end
    chk("sat_loss_count", bus.lock_loss_count, exp_cnt(255));

    // Asynchronous reset with the clock stopped, in HOLD and in RUN.
    repeat (7) cyc(1'b1, 1'b0);
    async_check("hold_async");
    count_release("restart_release_edge", 9);
    async_check("run_async");
    count_release("restart2_release_edge", 9);

    // Randomized lock runs and soft resets against the model.
    do_reset(1'b0);
    for (int k = 0; k < 120; k++) begin
      int len1;
      int len0;
      len1 = $urandom_range(1, 16);
      len0 = $urandom_range(1, 4);
      for (int j = 0; j < len1; j++) cyc(1'b1, $urandom_range(0, 7) == 0);
      for (int j = 0; j < len0; j++) cyc(1'b0, $urandom_range(0, 7) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
